muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle multiply/divide unit that owns the HI/LO register pair and supplies `hilo_q` to the ALU. It accepts mult, multu, div, divu, mthi and mtlo from the execute stage and runs the arithmetic iteratively over 33 cycles, replacing the single-cycle combinational `*`, `/` and `%` paths. While an operation runs it raises `busy`; the controller stalls any HI/LO reader or new HI/LO operation until `busy` falls.

## Interface
Parameters:
- `W`, default 32: operand width. HI/LO is 2·W.

Ports:
- `clk_cpu`  in  1: CPU clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: request strobe; sampled only while `busy`=0.
- `op`  in  3: operation code, one of MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
- `rs`  in  W: multiplicand, dividend, or source value for mthi/mtlo.
- `rt`  in  W: multiplier or divisor.
- `hilo_q`  out  2W: HI in [63:32], LO in [31:0].
- `busy`  out  1: an iterative operation is in progress.
- `done`  out  1: one-cycle pulse on the cycle HI/LO is written by mult or div.

## Operation
State machine states: IDLE, MUL, DIV, FIX.

- IDLE with `start`=1 and op = mthi or mtlo:
  - At the next edge, HI or LO takes `rs`; the other half is unchanged.
  - State stays IDLE; `busy` stays 0; `done` stays 0.
- IDLE with `start`=1 and op = mult/multu/div/divu:
  - Latch operand magnitudes. Signed ops take the absolute value; |−2^31| = 0x80000000, treated as unsigned.
  - Latch result signs:
    - product sign = sign(rs) XOR sign(rt);
    - quotient sign = sign(rs) XOR sign(rt);
    - remainder sign = sign(rs).
  - Clear the 6-bit iteration counter and go to MUL or DIV.
- MUL: shift-add, one multiplier bit per cycle, 2W-bit accumulator. After 32 iterations go to FIX.
- DIV: restoring division, one quotient bit per cycle, (W+1)-bit partial remainder. After 32 iterations go to FIX.
- FIX:
  - Negate the results whose latched sign is set.
  - Write HI/LO: mult gives the full 64-bit product; div gives HI = remainder and LO = quotient.
  - Pulse `done`; return to IDLE.
- Divide by zero (rt=0, signed or unsigned): runs the full latency with no special state. Result is HI = rs, LO = 0xFFFFFFFF. This is the natural result of restoring division plus the sign fix; the signed case must be forced to match it exactly.
- div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `start` while `busy`=1: ignored, with no effect on the running operation.
- `op` codes outside the six defined: treated as no-op, state stays IDLE.
- `rs`, `rt` and `op` need only be valid on the accept cycle.

## Timing
- Reset (asynchronous, any state including mid-operation):
  - state = IDLE, `hilo_q` = 0, `busy` = 0, `done` = 0, counter = 0.
  - Partial results are discarded.
- Accept edge T0 (IDLE, `start`=1, mult/div op): `busy` = 1 from T0 onward.
- Iterations occupy edges T1..T32.
- Edge T33 (FIX):
  - `hilo_q` updates;
  - `busy` = 0;
  - `done` = 1 for that one cycle.
- Back-to-back: a new `start` is accepted at T33, the same edge `busy` falls.
- Total: `busy` high for exactly 33 cycles; result visible 33 cycles after accept.
- mthi/mtlo: `hilo_q` updates at T0 + 1 edge; no `busy`.
- `hilo_q` is a pure register output with no combinational path from inputs.

## Structure
- Shared defines file holds:
  - MD_* op encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5;
  - state encoding;
  - the W/2W width macros already used for word and dword.
- One sub-module, `div_step`: combinational single restoring-division step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder and quotient bit.
  - Keeps the FSM file readable and can be unit-tested on its own.
- Multiplier step stays inline as a conditional add plus shift.

## Test plan
- mult rs=7, rt=0xFFFFFFFD (−3) → `busy` high 33 cycles, then `hilo_q` = 0xFFFFFFFF_FFFFFFEB, `done` pulses once.
- multu rs=rt=0xFFFFFFFF → `hilo_q` = 0xFFFFFFFE_00000001.
- div rs=0xFFFFFFF9 (−7), rt=2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; divu same operands → LO = 0x7FFFFFFC, HI = 1.
- divu rs=0x1234, rt=0 → HI = 0x1234, LO = 0xFFFFFFFF; div 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- mthi 0xAAAA0000, then mtlo 0x5555 → `hilo_q` = 0xAAAA0000_00005555 after two edges, `busy` never asserted.
- Start div, assert `start` with mult at cycle 10 (must be ignored), then assert `reset` at cycle 20 → `busy` = 0 and `hilo_q` = 0 immediately; a later mult 3×4 gives `hilo_q` = 12.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and widths for the multiply/divide unit.
package muldiv_unit_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned DWORD_W = 2 * WORD_W;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned CNT_W   = 6;

  localparam logic [OP_W-1:0] MD_MULT  = 3'd0;
  localparam logic [OP_W-1:0] MD_MULTU = 3'd1;
  localparam logic [OP_W-1:0] MD_DIV   = 3'd2;
  localparam logic [OP_W-1:0] MD_DIVU  = 3'd3;
  localparam logic [OP_W-1:0] MD_MTHI  = 3'd4;
  localparam logic [OP_W-1:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  // Ops that run the iterative datapath.
  function automatic logic is_arith_op(input logic [OP_W-1:0] op);
    return op <= MD_DIVU;
  endfunction

  function automatic logic is_signed_op(input logic [OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage request / HI-LO result bus of the multiply/divide unit.
interface muldiv_unit_if
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned W = WORD_W
);
  logic              start;
  logic [OP_W-1:0]   op;
  logic [W-1:0]      rs;
  logic [W-1:0]      rt;
  logic [2*W-1:0]    hilo_q;
  logic              busy;
  logic              done;

  modport master (output start, op, rs, rt, input hilo_q, busy, done);
  modport slave  (input start, op, rs, rt, output hilo_q, busy, done);
endinterface

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor if it fits.
module div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W:0]   rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] div_i,
  output logic [W:0]   rem_o,
  output logic         q_o
);
  logic [W+1:0] shifted;

  // Trial subtraction; the remainder is restored when the divisor does not fit.
  always_comb begin
    shifted = {rem_i, bit_i};
    q_o     = shifted >= {2'b00, div_i};
    rem_o   = (W+1)'(q_o ? (shifted - {2'b00, div_i}) : shifted);
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned W = WORD_W
) (
  input  logic         clk_cpu,
  input  logic         reset,
  muldiv_unit_if.slave md
);
  localparam int unsigned    DW        = 2 * W;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    a_q, a_d;      // mul: shifted multiplicand; div: divisor in low W bits
  logic [W-1:0]     b_q, b_d;      // mul: multiplier; div: dividend out / quotient in
  logic [DW-1:0]    acc_q, acc_d;  // mul: product; div: partial remainder in low W+1 bits
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;          // product / quotient sign
  logic             neg_rem_q, neg_rem_d;  // remainder sign
  logic [DW-1:0]    hilo_q, hilo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             load;
  logic             rs_neg, rt_neg;
  logic [W-1:0]     rs_mag, rt_mag;
  logic [W:0]       rem_next;
  logic             qbit;

  // Operand magnitudes and signs for a request on the bus.
  always_comb begin
    rs_neg = is_signed_op(md.op) & md.rs[W-1];
    rt_neg = is_signed_op(md.op) & md.rt[W-1];
    rs_mag = rs_neg ? W'(-md.rs) : md.rs;
    rt_mag = rt_neg ? W'(-md.rt) : md.rt;
  end

  div_step #(.W(W)) u_div_step (
    .rem_i (acc_q[W:0]),
    .bit_i (b_q[W-1]),
    .div_i (a_q[W-1:0]),
    .rem_o (rem_next),
    .q_o   (qbit)
  );

  // Next-state, datapath and HI/LO update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    hilo_d    = hilo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    load      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (md.start) begin
          if (md.op == MD_MTHI) begin
            hilo_d = {md.rs, hilo_q[W-1:0]};
          end else if (md.op == MD_MTLO) begin
            hilo_d = {hilo_q[DW-1:W], md.rs};
          end else if (is_arith_op(md.op)) begin
            load = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d = b_q[0] ? (acc_q + a_q) : acc_q;
        a_d   = {a_q[DW-2:0], 1'b0};
        b_d   = {1'b0, b_q[W-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_DIV: begin
        acc_d = {{(W-1){1'b0}}, rem_next};
        b_d   = {b_q[W-2:0], qbit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hilo_d = {neg_rem_q ? W'(-acc_q[W-1:0]) : acc_q[W-1:0],
                    neg_q     ? W'(-b_q)         : b_q};
        end else begin
          hilo_d = neg_q ? DW'(-acc_q) : acc_q;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        // Back-to-back accept; HI/LO moves are held off until busy falls.
        if (md.start && is_arith_op(md.op)) load = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      is_div_d  = is_div_op(md.op);
      // Divide by zero keeps the all-ones quotient unsigned-looking in the signed case.
      neg_d     = (rs_neg ^ rt_neg) & ~(is_div_op(md.op) && (md.rt == '0));
      neg_rem_d = rs_neg;
      a_d       = {{W{1'b0}}, is_div_op(md.op) ? rt_mag : rs_mag};
      b_d       = is_div_op(md.op) ? rs_mag : rt_mag;
      acc_d     = '0;
      cnt_d     = '0;
      busy_d    = 1'b1;
      state_d   = is_div_op(md.op) ? S_DIV : S_MUL;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hilo_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      hilo_q    <= hilo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign md.hilo_q = hilo_q;
  assign md.busy   = busy_q;
  assign md.done   = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, corner sequences, random ops vs model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk_cpu = 1'b0;
  logic reset;
  always #5 clk_cpu = ~clk_cpu;

  muldiv_unit_if #(.W(32)) md_if ();

  muldiv_unit #(.W(32)) dut (
    .clk_cpu (clk_cpu),
    .reset   (reset),
    .md      (md_if.slave)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] model_hilo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Architectural result of one op, from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] rs,
                                            input logic [31:0] rt, input logic [63:0] h);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    ua = {32'd0, rs};
    ub = {32'd0, rt};
    case (op)
      MD_MULT:  return 64'(sa * sb);
      MD_MULTU: return ua * ub;
      MD_DIV: begin
        if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      MD_DIVU: begin
        if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      MD_MTHI: return {rs, h[31:0]};
      MD_MTLO: return {h[63:32], rs};
      default: return h;
    endcase
  endfunction

  // Issue one op, then check latency, done pulse and HI/LO.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [63:0] exp);
    int n;
    int early;
    @(negedge clk_cpu);
    md_if.start = 1'b1;
    md_if.op    = op;
    md_if.rs    = rs;
    md_if.rt    = rt;
    @(negedge clk_cpu);
    md_if.start = 1'b0;
    md_if.op    = 3'($urandom_range(0, 7));
    md_if.rs    = $urandom;
    md_if.rt    = $urandom;
    if (op <= MD_DIVU) begin
      n = 0;
      early = 0;
      while (md_if.busy === 1'b1 && n < 100) begin
        n++;
        if (md_if.done !== 1'b0) early++;
        @(negedge clk_cpu);
      end
      check({name, " busy_cycles"}, 64'(n), 64'd33);
      check({name, " early_done"}, 64'(early), 64'd0);
      check({name, " done"}, 64'(md_if.done), 64'd1);
      check({name, " hilo"}, md_if.hilo_q, exp);
    end else begin
      check({name, " busy"}, 64'(md_if.busy), 64'd0);
      check({name, " done"}, 64'(md_if.done), 64'd0);
      check({name, " hilo"}, md_if.hilo_q, exp);
      @(negedge clk_cpu);
      check({name, " busy_next"}, 64'(md_if.busy), 64'd0);
    end
    model_hilo = exp;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [2:0]  rop;
    logic [31:0] rrs, rrt;

    vecs[0]  = '{MD_MULT,  32'd7,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9,  32'd2,         64'hFFFF_FFFF_FFFF_FFFD};
    vecs[3]  = '{MD_DIVU,  32'hFFFF_FFF9,  32'd2,         64'h0000_0001_7FFF_FFFC};
    vecs[4]  = '{MD_DIVU,  32'h0000_1234,  32'd0,         64'h0000_1234_FFFF_FFFF};
    vecs[5]  = '{MD_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
    vecs[6]  = '{MD_MTHI,  32'hAAAA_0000,  32'd0,         64'hAAAA_0000_8000_0000};
    vecs[7]  = '{MD_MTLO,  32'h0000_5555,  32'd0,         64'hAAAA_0000_0000_5555};
    vecs[8]  = '{MD_DIV,   32'hFFFF_FFF9,  32'd0,         64'hFFFF_FFF9_FFFF_FFFF};
    vecs[9]  = '{MD_MULT,  32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[10] = '{MD_DIV,   32'h8000_0000,  32'd0,         64'h8000_0000_FFFF_FFFF};
    vecs[11] = '{MD_MULTU, 32'd0,          32'h0001_2345, 64'h0000_0000_0000_0000};
    vecs[12] = '{MD_DIV,   32'd7,          32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};

    reset = 1'b1;
    md_if.start = 1'b0;
    md_if.op = MD_MULT;
    md_if.rs = '0;
    md_if.rt = '0;
    model_hilo = '0;
    repeat (2) @(negedge clk_cpu);
    check("reset hilo", md_if.hilo_q, 64'd0);
    check("reset busy", 64'(md_if.busy), 64'd0);
    check("reset done", 64'(md_if.done), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].exp);
    end

    run_op("undef_op6", 3'd6, 32'h1111_1111, 32'h2222_2222, model_hilo);
    run_op("undef_op7", 3'd7, 32'h3333_3333, 32'h4444_4444, model_hilo);

    // Start during busy must not disturb the running divide.
    @(negedge clk_cpu);
    md_if.start = 1'b1; md_if.op = MD_DIV; md_if.rs = 32'd100; md_if.rt = 32'd7;
    @(negedge clk_cpu);
    md_if.start = 1'b0;
    n = 0;
    while (md_if.busy === 1'b1 && n < 100) begin
      n++;
      if (n == 10) begin
        md_if.start = 1'b1; md_if.op = MD_MULT; md_if.rs = 32'd3; md_if.rt = 32'd4;
      end else begin
        md_if.start = 1'b0;
      end
      @(negedge clk_cpu);
    end
    check("ignored_start busy_cycles", 64'(n), 64'd33);
    check("ignored_start done", 64'(md_if.done), 64'd1);
    check("ignored_start hilo", md_if.hilo_q, 64'h0000_0002_0000_000E);
    @(negedge clk_cpu);
    check("ignored_start done_drop", 64'(md_if.done), 64'd0);
    check("ignored_start idle", 64'(md_if.busy), 64'd0);
    model_hilo = 64'h0000_0002_0000_000E;

    // Back-to-back: second op accepted on the edge the first one completes.
    @(negedge clk_cpu);
    md_if.start = 1'b1; md_if.op = MD_MULT; md_if.rs = 32'd3; md_if.rt = 32'd5;
    @(negedge clk_cpu);
    md_if.start = 1'b0;
    repeat (32) @(negedge clk_cpu);
    check("b2b busy_last", 64'(md_if.busy), 64'd1);
    md_if.start = 1'b1; md_if.op = MD_MULTU; md_if.rs = 32'd6; md_if.rt = 32'd7;
    @(negedge clk_cpu);
    md_if.start = 1'b0;
    check("b2b first hilo", md_if.hilo_q, 64'd15);
    check("b2b first done", 64'(md_if.done), 64'd1);
    check("b2b second busy", 64'(md_if.busy), 64'd1);
    n = 0;
    @(negedge clk_cpu);
    while (md_if.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk_cpu);
    end
    check("b2b second busy_cycles", 64'(n), 64'd32);
    check("b2b second done", 64'(md_if.done), 64'd1);
    check("b2b second hilo", md_if.hilo_q, 64'd42);

    // Asynchronous reset mid-divide discards everything.
    @(negedge clk_cpu);
    md_if.start = 1'b1; md_if.op = MD_DIV; md_if.rs = 32'd1000; md_if.rt = 32'd3;
    @(negedge clk_cpu);
    md_if.start = 1'b0;
    repeat (19) @(negedge clk_cpu);
    check("midreset busy_before", 64'(md_if.busy), 64'd1);
    reset = 1'b1;
    #1;
    check("midreset busy", 64'(md_if.busy), 64'd0);
    check("midreset hilo", md_if.hilo_q, 64'd0);
    check("midreset done", 64'(md_if.done), 64'd0);
    @(negedge clk_cpu);
    reset = 1'b0;
    model_hilo = '0;
    @(negedge clk_cpu);
    check("postreset idle", 64'(md_if.busy), 64'd0);
    run_op("postreset mult", MD_MULT, 32'd3, 32'd4, 64'd12);

    // Random ops, including corner operands, against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0:       rrs = 32'd0;
        1:       rrs = 32'h8000_0000;
        2:       rrs = 32'hFFFF_FFFF;
        default: rrs = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rrt = 32'd0;
        1:       rrt = 32'hFFFF_FFFF;
        2:       rrt = 32'd1;
        default: rrt = $urandom;
      endcase
      run_op($sformatf("rand%0d op%0d rs=%h rt=%h", i, rop, rrs, rrt), rop, rrs, rrt,
             ref_model(rop, rrs, rrt, model_hilo));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
